// File: rtl/wave_pwm_out.sv
// PWM DAC output stage: picks one of six waveform samples, attenuates it around
// midscale, and plays it as a 255-cycle PWM frame repeated REPEAT times per sample.
module wave_pwm_out #(
  parameter int unsigned REPEAT = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] square,
  input  logic [7:0] triangle,
  input  logic [7:0] reciprocal,
  input  logic [7:0] sin,
  input  logic [7:0] full,
  input  logic [7:0] half,
  input  logic [2:0] sel,
  input  logic [1:0] amp,
  output logic       pwm_out,
  output logic       sample_tick,
  output logic [7:0] sample_out
);

  localparam logic [7:0] MIDSCALE = 8'd128;
  localparam logic [7:0] CNT_LAST = 8'd254;
  localparam logic [3:0] REP_LAST = 4'(REPEAT - 1);

  logic [7:0] cnt_q, cnt_d;
  logic [3:0] rep_q, rep_d;
  logic [7:0] duty_q, duty_d;
  logic       pwm_q, pwm_d;
  logic       tick_q, tick_d;

  logic [7:0] sel_val;
  logic [7:0] s;

  always_comb begin
    sel_val = MIDSCALE;
    case (sel)
      3'd0:    sel_val = square;
      3'd1:    sel_val = triangle;
      3'd2:    sel_val = reciprocal;
      3'd3:    sel_val = sin;
      3'd4:    sel_val = full;
      3'd5:    sel_val = half;
      default: sel_val = MIDSCALE;
    endcase
  end

  // Attenuation shrinks the swing toward 128; the offsets keep the result centred.
  always_comb begin
    s = MIDSCALE;
    case (amp)
      2'd0:    s = sel_val;
      2'd1:    s = {1'b0, sel_val[7:1]} + 8'd64;
      2'd2:    s = {2'b00, sel_val[7:2]} + 8'd96;
      default: s = MIDSCALE;
    endcase
  end

  always_comb begin
    cnt_d  = cnt_q;
    rep_d  = rep_q;
    duty_d = duty_q;
    pwm_d  = 1'b0;
    tick_d = 1'b0;
    if (!enable) begin
      cnt_d = '0;
      rep_d = '0;
    end else begin
      // cnt never reaches 255, so duty 255 stays high for the whole frame.
      pwm_d = (cnt_q < duty_q);
      if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
        if (rep_q == REP_LAST) begin
          rep_d  = '0;
          duty_d = s;
          tick_d = 1'b1;
        end else begin
          rep_d = rep_q + 4'd1;
        end
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      rep_q  <= '0;
      duty_q <= MIDSCALE;
      pwm_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      rep_q  <= rep_d;
      duty_q <= duty_d;
      pwm_q  <= pwm_d;
      tick_q <= tick_d;
    end
  end

  assign pwm_out     = pwm_q;
  assign sample_tick = tick_q;
  assign sample_out  = duty_q;

endmodule

// File: tb/tb_wave_pwm_out.sv
// Directed bench for wave_pwm_out: one instance with REPEAT=1 and one with REPEAT=4
// share all inputs; expected values are hand-computed from the frame timing.
module tb_wave_pwm_out;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic [7:0] square = 8'd0, triangle = 8'd0, reciprocal = 8'd0;
  logic [7:0] sin = 8'd0, full = 8'd0, half = 8'd0;
  logic [2:0] sel = 3'd0;
  logic [1:0] amp = 2'd0;

  logic       pwm1, tick1, pwm4, tick4;
  logic [7:0] sample1, sample4;

  int vectors = 0;
  int miscompares = 0;

  wave_pwm_out #(.REPEAT(1)) dut1 (
    .clock(clock), .reset(reset), .enable(enable),
    .square(square), .triangle(triangle), .reciprocal(reciprocal),
    .sin(sin), .full(full), .half(half), .sel(sel), .amp(amp),
    .pwm_out(pwm1), .sample_tick(tick1), .sample_out(sample1)
  );

  wave_pwm_out #(.REPEAT(4)) dut4 (
    .clock(clock), .reset(reset), .enable(enable),
    .square(square), .triangle(triangle), .reciprocal(reciprocal),
    .sin(sin), .full(full), .half(half), .sel(sel), .amp(amp),
    .pwm_out(pwm4), .sample_tick(tick4), .sample_out(sample4)
  );

  always #5 clock = ~clock;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Runs one 255-cycle frame of dut1, counting high samples and the first tick position.
  task automatic run_frame(output int highs, output int tick_at);
    highs = 0;
    tick_at = 0;
    for (int i = 1; i <= 255; i++) begin
      step();
      if (pwm1) highs++;
      if (tick1 && tick_at == 0) tick_at = i;
    end
  endtask

  task automatic set_inputs(input logic [2:0] s, input logic [1:0] a, input logic [7:0] v);
    square = 8'd11; triangle = 8'd22; reciprocal = 8'd33;
    sin = 8'd44; full = 8'd55; half = 8'd66;
    case (s)
      3'd0: square = v;
      3'd1: triangle = v;
      3'd2: reciprocal = v;
      3'd3: sin = v;
      3'd4: full = v;
      3'd5: half = v;
      default: ;
    endcase
    sel = s;
    amp = a;
  endtask

  task automatic test_reset();
    int highs, tick_at;
    reset = 1'b1;
    enable = 1'b0;
    set_inputs(3'd0, 2'd0, 8'd255);
    step(); step(); step();
    vectors++;
    if (pwm1 !== 1'b0) begin miscompares++; $display("FAIL reset_pwm: got %b want 0", pwm1); end
    vectors++;
    if (tick1 !== 1'b0) begin miscompares++; $display("FAIL reset_tick: got %b want 0", tick1); end
    vectors++;
    if (sample1 !== 8'd128) begin miscompares++; $display("FAIL reset_sample1: got %0d want 128", sample1); end
    vectors++;
    if (sample4 !== 8'd128) begin miscompares++; $display("FAIL reset_sample4: got %0d want 128", sample4); end
    reset = 1'b0;
    enable = 1'b1;
    run_frame(highs, tick_at);
    $display("first frame: highs=%0d tick_at=%0d sample=%0d", highs, tick_at, sample1);
    vectors++;
    if (highs != 128) begin miscompares++; $display("FAIL first_frame_highs: got %0d want 128", highs); end
    vectors++;
    if (tick_at != 255) begin miscompares++; $display("FAIL first_tick_pos: got %0d want 255", tick_at); end
    vectors++;
    if (sample1 !== 8'd255) begin miscompares++; $display("FAIL first_load: got %0d want 255", sample1); end
  endtask

  task automatic test_full_scale();
    int highs, tick_at;
    square = 8'd0;
    run_frame(highs, tick_at);
    $display("duty 255 frame: highs=%0d tick_at=%0d sample=%0d", highs, tick_at, sample1);
    vectors++;
    if (highs != 255) begin miscompares++; $display("FAIL duty255_highs: got %0d want 255", highs); end
    vectors++;
    if (tick_at != 255) begin miscompares++; $display("FAIL duty255_tick: got %0d want 255", tick_at); end
    vectors++;
    if (sample1 !== 8'd0) begin miscompares++; $display("FAIL load_zero: got %0d want 0", sample1); end
    run_frame(highs, tick_at);
    $display("duty 0 frame: highs=%0d tick_at=%0d", highs, tick_at);
    vectors++;
    if (highs != 0) begin miscompares++; $display("FAIL duty0_highs: got %0d want 0", highs); end
    vectors++;
    if (tick_at != 255) begin miscompares++; $display("FAIL duty0_tick: got %0d want 255", tick_at); end
  endtask

  task automatic test_amp();
    logic [2:0] v_sel [11] = '{3'd3, 3'd3, 3'd3, 3'd3, 3'd6, 3'd1, 3'd2, 3'd4, 3'd5, 3'd7, 3'd0};
    logic [1:0] v_amp [11] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd0, 2'd0, 2'd2, 2'd1, 2'd1, 2'd2, 2'd2};
    logic [7:0] v_val [11] = '{8'd200, 8'd200, 8'd200, 8'd200, 8'd250, 8'd37, 8'd90, 8'd77, 8'd255, 8'd250, 8'd255};
    logic [7:0] v_exp [11] = '{8'd164, 8'd146, 8'd128, 8'd200, 8'd128, 8'd37, 8'd118, 8'd102, 8'd191, 8'd128, 8'd159};
    int prev = 0;
    int highs, tick_at;
    for (int k = 0; k < 11; k++) begin
      set_inputs(v_sel[k], v_amp[k], v_val[k]);
      run_frame(highs, tick_at);
      $display("amp vec %0d: sel=%0d amp=%0d val=%0d sample=%0d highs=%0d", k, v_sel[k], v_amp[k], v_val[k], sample1, highs);
      vectors++;
      if (sample1 !== v_exp[k]) begin
        miscompares++;
        $display("FAIL amp_vec%0d_sample: got %0d want %0d", k, sample1, v_exp[k]);
      end
      vectors++;
      if (highs != prev) begin
        miscompares++;
        $display("FAIL amp_vec%0d_highs: got %0d want %0d", k, highs, prev);
      end
      prev = int'(v_exp[k]);
    end
  endtask

  task automatic test_repeat();
    int t;
    reset = 1'b1;
    step(); step();
    set_inputs(3'd0, 2'd0, 8'd10);
    reset = 1'b0;
    enable = 1'b1;
    t = 0;
    for (int i = 1; i <= 1100 && t == 0; i++) begin
      step();
      if (tick4) t = i;
    end
    $display("repeat4 first tick at %0d sample=%0d", t, sample4);
    vectors++;
    if (t != 1020) begin miscompares++; $display("FAIL rep4_first_tick: got %0d want 1020", t); end
    vectors++;
    if (sample4 !== 8'd10) begin miscompares++; $display("FAIL rep4_first_load: got %0d want 10", sample4); end
    t = 0;
    for (int i = 1; i <= 1100 && t == 0; i++) begin
      step();
      if (i == 500) square = 8'd20;
      if (i == 765) begin
        vectors++;
        if (sample1 !== 8'd20) begin miscompares++; $display("FAIL rep1_midgroup_load: got %0d want 20", sample1); end
        vectors++;
        if (sample4 !== 8'd10) begin miscompares++; $display("FAIL rep4_midgroup_hold: got %0d want 10", sample4); end
      end
      if (tick4) t = i;
    end
    $display("repeat4 tick spacing %0d sample=%0d", t, sample4);
    vectors++;
    if (t != 1020) begin miscompares++; $display("FAIL rep4_spacing: got %0d want 1020", t); end
    vectors++;
    if (sample4 !== 8'd20) begin miscompares++; $display("FAIL rep4_second_load: got %0d want 20", sample4); end
  endtask

  task automatic test_enable();
    int bad, highs, tick_at;
    square = 8'd50;
    for (int i = 0; i < 100; i++) step();
    enable = 1'b0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (pwm1 !== 1'b0 || tick1 !== 1'b0 || pwm4 !== 1'b0 || tick4 !== 1'b0) bad++;
    end
    $display("disabled window: bad=%0d sample=%0d", bad, sample1);
    vectors++;
    if (bad != 0) begin miscompares++; $display("FAIL disable_outputs: got %0d bad cycles want 0", bad); end
    vectors++;
    if (sample1 !== 8'd20) begin miscompares++; $display("FAIL disable_hold: got %0d want 20", sample1); end
    enable = 1'b1;
    run_frame(highs, tick_at);
    $display("re-enabled frame: highs=%0d tick_at=%0d sample=%0d", highs, tick_at, sample1);
    vectors++;
    if (highs != 20) begin miscompares++; $display("FAIL reenable_highs: got %0d want 20", highs); end
    vectors++;
    if (tick_at != 255) begin miscompares++; $display("FAIL reenable_tick: got %0d want 255", tick_at); end
    vectors++;
    if (sample1 !== 8'd50) begin miscompares++; $display("FAIL reenable_load: got %0d want 50", sample1); end
    square = 8'd60;
    for (int i = 0; i < 254; i++) step();
    enable = 1'b0;
    step();
    $display("disable at frame end: tick=%0d sample=%0d", tick1, sample1);
    vectors++;
    if (tick1 !== 1'b0) begin miscompares++; $display("FAIL drop_at_254_tick: got %b want 0", tick1); end
    vectors++;
    if (sample1 !== 8'd50) begin miscompares++; $display("FAIL drop_at_254_load: got %0d want 50", sample1); end
    enable = 1'b1;
  endtask

  task automatic test_reset_mid();
    int highs, tick_at;
    square = 8'd200;
    run_frame(highs, tick_at);
    $display("pre-reset frame: highs=%0d tick_at=%0d sample=%0d", highs, tick_at, sample1);
    vectors++;
    if (highs != 50) begin miscompares++; $display("FAIL held_duty_highs: got %0d want 50", highs); end
    vectors++;
    if (sample1 !== 8'd200) begin miscompares++; $display("FAIL load_200: got %0d want 200", sample1); end
    for (int i = 0; i < 100; i++) step();
    vectors++;
    if (pwm1 !== 1'b1) begin miscompares++; $display("FAIL pre_reset_pwm: got %b want 1", pwm1); end
    reset = 1'b1;
    #1;
    $display("async reset: pwm=%0d tick=%0d sample1=%0d sample4=%0d", pwm1, tick1, sample1, sample4);
    vectors++;
    if (pwm1 !== 1'b0) begin miscompares++; $display("FAIL async_reset_pwm: got %b want 0", pwm1); end
    vectors++;
    if (tick1 !== 1'b0) begin miscompares++; $display("FAIL async_reset_tick: got %b want 0", tick1); end
    vectors++;
    if (sample1 !== 8'd128) begin miscompares++; $display("FAIL async_reset_sample: got %0d want 128", sample1); end
    step(); step();
    reset = 1'b0;
    run_frame(highs, tick_at);
    $display("post-reset frame: highs=%0d tick_at=%0d", highs, tick_at);
    vectors++;
    if (highs != 128) begin miscompares++; $display("FAIL post_reset_highs: got %0d want 128", highs); end
    vectors++;
    if (tick_at != 255) begin miscompares++; $display("FAIL post_reset_tick: got %0d want 255", tick_at); end
  endtask

  initial begin
    test_reset();
    test_full_scale();
    test_amp();
    test_repeat();
    test_enable();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
